// File: rtl/intseq_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | intseq_pkg : state/source encodings and vector constants for intseq   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package intseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_SERVICE = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SRC_RST = 2'b00,
    SRC_NMI = 2'b01,
    SRC_IRQ = 2'b10
  } src_e;

  localparam logic [7:0] VEC_NMI     = 8'hFA;
  localparam logic [7:0] VEC_RST     = 8'hFC;
  localparam logic [7:0] VEC_IRQ     = 8'hFE;
  localparam logic [3:0] SVC_TIMEOUT = 4'd15;

  function automatic logic [7:0] vec_of(input src_e src);
    case (src)
      SRC_NMI: return VEC_NMI;
      SRC_IRQ: return VEC_IRQ;
      default: return VEC_RST;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/intseq_syncff.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | syncff : 2-flop synchronizer, async active-low reset, resets to 1     |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module syncff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/intseq.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | intseq : RESET/NMI/IRQ interrupt sequencer with service timeout       |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module intseq
  import intseq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       irqn,
  input  logic       nmin,
  input  logic       iflag,
  input  logic       sync,
  input  logic       brkdone,
  output logic       irq,
  output logic [7:0] vecl,
  output logic       hwint,
  output logic       err
);

  logic irqn_s, nmin_s;

  syncff u_sync_irqn (.clk(clk), .rst(rst), .d(irqn), .q(irqn_s));
  syncff u_sync_nmin (.clk(clk), .rst(rst), .d(nmin), .q(nmin_s));

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic        irq_q, irq_d;
  logic        hwint_q, hwint_d;
  logic        err_q, err_d;
  logic [3:0]  timer_q, timer_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        rst_pend_q, rst_pend_d;
  logic        nmi_prev_q, nmi_prev_d;

  logic        irq_req, nmi_fall, any_pend;

  assign irq_req  = ~irqn_s & ~iflag;
  assign nmi_fall = nmi_prev_q & ~nmin_s;
  assign any_pend = rst_pend_q | nmi_pend_q | irq_req;

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    irq_d      = irq_q;
    hwint_d    = hwint_q;
    err_d      = err_q;
    timer_d    = timer_q;
    nmi_pend_d = nmi_pend_q;
    rst_pend_d = rst_pend_q;
    nmi_prev_d = nmin_s;

    case (state_q)
      ST_IDLE: begin
        if (any_pend) begin
          state_d = ST_ARMED;
          irq_d   = 1'b1;
        end
      end
      ST_ARMED: begin
        if (sync) begin
          state_d = ST_SERVICE;
          irq_d   = 1'b0;
          hwint_d = 1'b1;
          timer_d = 4'd0;
          // Opcode 00 is already forced once sync is seen, so a request
          // withdrawn in this very cycle is still serviced as IRQ.
          if (rst_pend_q) begin
            src_d      = SRC_RST;
            rst_pend_d = 1'b0;
          end else if (nmi_pend_q) begin
            src_d      = SRC_NMI;
            nmi_pend_d = 1'b0;
          end else begin
            src_d      = SRC_IRQ;
          end
        end else if (!any_pend) begin
          state_d = ST_IDLE;
          irq_d   = 1'b0;
        end
      end
      ST_SERVICE: begin
        if (brkdone) begin
          state_d = ST_IDLE;
          hwint_d = 1'b0;
          timer_d = 4'd0;
        end else if (timer_q == SVC_TIMEOUT) begin
          state_d = ST_IDLE;
          hwint_d = 1'b0;
          timer_d = 4'd0;
          err_d   = 1'b1;
        end else begin
          timer_d = timer_q + 4'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
        hwint_d = 1'b0;
        timer_d = 4'd0;
      end
    endcase

    // A fresh NMI edge wins over the clear of a coincident NMI commit.
    if (nmi_fall) nmi_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      src_q      <= SRC_RST;
      irq_q      <= 1'b0;
      hwint_q    <= 1'b0;
      err_q      <= 1'b0;
      timer_q    <= 4'd0;
      nmi_pend_q <= 1'b0;
      rst_pend_q <= 1'b1;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      irq_q      <= irq_d;
      hwint_q    <= hwint_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      nmi_pend_q <= nmi_pend_d;
      rst_pend_q <= rst_pend_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  assign irq   = irq_q;
  assign vecl  = vec_of(src_q);
  assign hwint = hwint_q;
  assign err   = err_q;

endmodule
`default_nettype wire
